// File: rtl/mmio_uart_port.sv
// rtl/mmio_uart_port.sv - MMIO output/input port and 8N1 TX FIFO responder on the MIPS data bus; define MMIO_UART_PARITY_EN for an even-parity bit
module mmio_uart_port #(
  parameter logic [31:0] BASE_ADDR  = 32'h1001_0000,
  parameter int          CLK_DIV    = 16,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  input  logic        MemWrite,
  input  logic        MemRead,
  output logic [31:0] ReadData,
  output logic        Hit,
  input  logic [7:0]  PortIn,
  output logic [31:0] PortOut,
  output logic        TxD,
  output logic        TxBusy
);

  localparam int          AW          = $clog2(FIFO_DEPTH);
  localparam logic [15:0] BAUD_RELOAD = 16'(CLK_DIV - 1);
  localparam logic [4:0]  FIFO_FULL   = 5'(FIFO_DEPTH);
`ifdef MMIO_UART_PARITY_EN
  localparam logic        PARITY_FLAG = 1'b1;
`else
  localparam logic        PARITY_FLAG = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  // Bus decode
  logic [1:0] reg_sel;
  logic       hit;
  logic       wr_en;
  logic       wr_port;
  logic       push_req;
  logic       wr_status;
  logic       unused_addr_bits;

  assign hit              = (Address[31:4] == BASE_ADDR[31:4]);
  assign Hit              = hit;
  assign reg_sel          = Address[3:2];
  assign wr_en            = MemWrite && hit;
  assign wr_port          = wr_en && (reg_sel == 2'd0);
  assign push_req         = wr_en && (reg_sel == 2'd2);
  assign wr_status        = wr_en && (reg_sel == 2'd3);
  assign unused_addr_bits = ^Address[1:0];

  // Output port and input synchronizer
  logic [31:0] port_out;
  logic [7:0]  sync_1;
  logic [7:0]  sync_2;

  assign PortOut = port_out;

  // Output port register, written by stores to offset 0
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      port_out <= 32'h0;
    end else if (wr_port) begin
      port_out <= WriteData;
    end
  end

  // Two-flop synchronizer for the asynchronous input port
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_1 <= 8'h0;
      sync_2 <= 8'h0;
    end else begin
      sync_1 <= PortIn;
      sync_2 <= sync_1;
    end
  end

  // TX FIFO
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [4:0]    count;
  logic          full;
  logic          empty;
  logic          push;
  logic          tx_pop;
  logic          overflow;

  // Full is taken from the pre-edge count, so a push beside a pop is still refused when full
  assign full  = (count == FIFO_FULL);
  assign empty = (count == 5'd0);
  assign push  = push_req && !full;

  // FIFO storage; no reset needed since count gates every read
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= WriteData[7:0];
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= 5'd0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (tx_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, tx_pop})
        2'b10:   count <= count + 5'd1;
        2'b01:   count <= count - 5'd1;
        default: count <= count;
      endcase
    end
  end

  // Sticky overflow; a rejected push outranks a clear in the same cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow <= 1'b0;
    end else if (push_req && full) begin
      overflow <= 1'b1;
    end else if (wr_status && WriteData[2]) begin
      overflow <= 1'b0;
    end
  end

  // Serial transmitter
  tx_state_t  state;
  tx_state_t  state_n;
  logic [15:0] baud_cnt;
  logic [15:0] baud_n;
  logic [2:0]  bit_cnt;
  logic [2:0]  bit_n;
  logic [7:0]  shift;
  logic [7:0]  shift_n;
  logic        parity_bit;
  logic        parity_n;
  logic        tx_line;
  logic        baud_done;

  assign baud_done = (baud_cnt == 16'd0);
  assign TxD       = tx_line;
  assign TxBusy    = (state != IDLE);

  // TX state register; every state change reloads the baud counter so bits never drift
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      baud_cnt   <= 16'd0;
      bit_cnt    <= 3'd0;
      shift      <= 8'h0;
      parity_bit <= 1'b0;
    end else begin
      state      <= state_n;
      baud_cnt   <= baud_n;
      bit_cnt    <= bit_n;
      shift      <= shift_n;
      parity_bit <= parity_n;
    end
  end

  // TX next-state and line drive
  always_comb begin
    state_n  = state;
    baud_n   = baud_cnt;
    bit_n    = bit_cnt;
    shift_n  = shift;
    parity_n = parity_bit;
    tx_pop   = 1'b0;
    tx_line  = 1'b1;
    case (state)
      IDLE: begin
        tx_line = 1'b1;
        if (!empty) begin
          tx_pop   = 1'b1;
          shift_n  = fifo_mem[rd_ptr];
          parity_n = ^fifo_mem[rd_ptr];
          baud_n   = BAUD_RELOAD;
          state_n  = START;
        end
      end
      START: begin
        tx_line = 1'b0;
        if (baud_done) begin
          baud_n  = BAUD_RELOAD;
          bit_n   = 3'd0;
          state_n = DATA;
        end else begin
          baud_n = baud_cnt - 16'd1;
        end
      end
      DATA: begin
        tx_line = shift[0];
        if (baud_done) begin
          baud_n = BAUD_RELOAD;
          if (bit_cnt == 3'd7) begin
`ifdef MMIO_UART_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end else begin
            bit_n   = bit_cnt + 3'd1;
            shift_n = {1'b0, shift[7:1]};
          end
        end else begin
          baud_n = baud_cnt - 16'd1;
        end
      end
`ifdef MMIO_UART_PARITY_EN
      PARITY: begin
        tx_line = parity_bit;
        if (baud_done) begin
          baud_n  = BAUD_RELOAD;
          state_n = STOP;
        end else begin
          baud_n = baud_cnt - 16'd1;
        end
      end
`endif
      STOP: begin
        tx_line = 1'b1;
        if (baud_done) begin
          state_n = IDLE;
        end else begin
          baud_n = baud_cnt - 16'd1;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Load data mux; zero whenever the access is not a load into this window
  logic [31:0] status;

  assign status = {23'h0, count, PARITY_FLAG, overflow, TxBusy, full};

  always_comb begin
    ReadData = 32'h0;
    if (MemRead && hit) begin
      case (reg_sel)
        2'd0:    ReadData = port_out;
        2'd1:    ReadData = {24'h0, sync_2};
        2'd2:    ReadData = 32'h0;
        default: ReadData = status;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart_port.sv
// tb/tb_mmio_uart_port.sv - scoreboard bench for mmio_uart_port with CLK_DIV=4
module tb_mmio_uart_port;

  localparam logic [31:0] BASE = 32'h1001_0000;
`ifdef MMIO_UART_PARITY_EN
  localparam logic [31:0] PB    = 32'h8;
  localparam int          FRAME = 44;
`else
  localparam logic [31:0] PB    = 32'h0;
  localparam int          FRAME = 40;
`endif

  logic        clk;
  logic        reset;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic        MemWrite;
  logic        MemRead;
  logic [31:0] ReadData;
  logic        Hit;
  logic [7:0]  PortIn;
  logic [31:0] PortOut;
  logic        TxD;
  logic        TxBusy;

  int tests = 0;
  int fails = 0;

  logic [31:0] rd_exp_q [$];
  logic        rd_hit_q [$];
  logic [7:0]  tx_q [$];
  logic        rst_seen;

  mmio_uart_port #(
    .BASE_ADDR (BASE),
    .CLK_DIV   (4),
    .FIFO_DEPTH(4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .Address  (Address),
    .WriteData(WriteData),
    .MemWrite (MemWrite),
    .MemRead  (MemRead),
    .ReadData (ReadData),
    .Hit      (Hit),
    .PortIn   (PortIn),
    .PortOut  (PortOut),
    .TxD      (TxD),
    .TxBusy   (TxBusy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    Address   = a;
    WriteData = d;
    MemWrite  = 1'b1;
    tick();
    MemWrite  = 1'b0;
  endtask

  task automatic rd_start(input logic [31:0] a, input logic [31:0] exp, input logic exp_hit);
    Address = a;
    MemRead = 1'b1;
    rd_exp_q.push_back(exp);
    rd_hit_q.push_back(exp_hit);
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] exp, input logic exp_hit);
    rd_start(a, exp, exp_hit);
    tick();
    MemRead = 1'b0;
  endtask

  // Load monitor: every cycle with MemRead high consumes one expected response
  logic [31:0] mon_exp;
  logic        mon_hit;
  always @(negedge clk) begin
    if (MemRead) begin
      if (rd_exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL rd_unexpected: load seen with ReadData %h, required no load", ReadData);
      end else begin
        mon_exp = rd_exp_q.pop_front();
        mon_hit = rd_hit_q.pop_front();
        chk("ReadData", ReadData, mon_exp);
        chk("Hit", {31'h0, Hit}, {31'h0, mon_hit});
      end
    end
  end

  always @(negedge reset) rst_seen = 1'b1;

  // Serial monitor: decodes frames at the first negedge of each bit and scores them
  logic [7:0] rx_byte;
  logic [7:0] rx_exp;
  logic       rx_stop;
`ifdef MMIO_UART_PARITY_EN
  logic       rx_par;
`endif
  initial begin
    forever begin
      @(negedge clk);
      if (reset && (TxD == 1'b0)) begin
        rst_seen = 1'b0;
        for (int b = 0; b < 8; b++) begin
          repeat (4) @(negedge clk);
          rx_byte[b] = TxD;
        end
`ifdef MMIO_UART_PARITY_EN
        repeat (4) @(negedge clk);
        rx_par = TxD;
`endif
        repeat (4) @(negedge clk);
        rx_stop = TxD;
        if (!rst_seen) begin
          if (tx_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL rx_unexpected: got frame %h, required none", rx_byte);
          end else begin
            rx_exp = tx_q.pop_front();
            chk("rx_byte", {24'h0, rx_byte}, {24'h0, rx_exp});
            chk("rx_stop", {31'h0, rx_stop}, 32'h1);
`ifdef MMIO_UART_PARITY_EN
            chk("rx_parity", {31'h0, rx_par}, {31'h0, ^rx_exp});
`endif
          end
        end
      end
    end
  end

  int n;
  int g;
  int bad;

  initial begin
    reset     = 1'b0;
    Address   = 32'h0;
    WriteData = 32'h0;
    MemWrite  = 1'b0;
    MemRead   = 1'b0;
    PortIn    = 8'h00;
    rst_seen  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_TxD", {31'h0, TxD}, 32'h1);
    chk("rst_TxBusy", {31'h0, TxBusy}, 32'h0);
    chk("rst_PortOut", PortOut, 32'h0);
    load(BASE + 32'hC, 32'h0 | PB, 1'b1);
    reset = 1'b1;
    tick();

    // Output port and decode
    store(BASE + 32'h0, 32'hDEAD_BEEF);
    chk("PortOut_after_store", PortOut, 32'hDEAD_BEEF);
    load(BASE + 32'h0, 32'hDEAD_BEEF, 1'b1);
    load(BASE + 32'h2, 32'hDEAD_BEEF, 1'b1);
    load(BASE + 32'h10, 32'h0, 1'b0);
    load(BASE + 32'h8, 32'h0, 1'b1);
    store(BASE + 32'h10, 32'h1234_5678);
    chk("PortOut_miss_store", PortOut, 32'hDEAD_BEEF);
    Address = BASE;
    @(negedge clk);
    chk("ReadData_no_strobe", ReadData, 32'h0);
    tick();

    // Input port synchronizer latency
    PortIn = 8'hA5;
    load(BASE + 32'h4, 32'h0, 1'b1);
    load(BASE + 32'h4, 32'h0, 1'b1);
    load(BASE + 32'h4, 32'hA5, 1'b1);
    load(BASE + 32'h4, 32'hA5, 1'b1);

    // Single frame 0x55
    tx_q.push_back(8'h55);
    store(BASE + 32'h8, 32'h55);
    rd_start(BASE + 32'hC, 32'h10 | PB, 1'b1);
    @(negedge clk);
    chk("TxD_before_pop", {31'h0, TxD}, 32'h1);
    chk("TxBusy_before_pop", {31'h0, TxBusy}, 32'h0);
    tick();
    MemRead = 1'b0;
    @(negedge clk);
    chk("TxD_start", {31'h0, TxD}, 32'h0);
    chk("TxBusy_start", {31'h0, TxBusy}, 32'h1);
    n = 1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!TxBusy) break;
      n++;
    end
    chk("busy_len_55", n, FRAME);
    repeat (3) tick();

    // Six pushes: one popped, four queued, sixth dropped
    for (int i = 1; i <= 6; i++) begin
      if (i <= 5) tx_q.push_back(8'(i));
      store(BASE + 32'h8, 32'(i));
    end
    load(BASE + 32'hC, 32'h47 | PB, 1'b1);
    store(BASE + 32'hC, 32'h4);
    load(BASE + 32'hC, 32'h43 | PB, 1'b1);
    store(BASE + 32'h8, 32'h07);
    load(BASE + 32'hC, 32'h47 | PB, 1'b1);
    store(BASE + 32'hC, 32'hFFFF_FFFB);
    load(BASE + 32'hC, 32'h47 | PB, 1'b1);
    store(BASE + 32'hC, 32'h4);
    load(BASE + 32'hC, 32'h43 | PB, 1'b1);

    // Back-to-back frames: one idle cycle between, full length each
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!TxBusy) break;
    end
    for (int f = 1; f <= 4; f++) begin
      g = 1;
      for (int i = 0; i < 200; i++) begin
        @(negedge clk);
        if (TxBusy) break;
        g++;
      end
      chk("idle_gap", g, 1);
      n = 1;
      for (int i = 0; i < 200; i++) begin
        @(negedge clk);
        if (!TxBusy) break;
        n++;
      end
      chk("busy_len_burst", n, FRAME);
    end
    repeat (10) tick();
    chk("tx_q_drained", tx_q.size(), 0);
    load(BASE + 32'hC, 32'h0 | PB, 1'b1);

    // Reset during data bit 3 of 0xA3 (bit 3 is 0)
    store(BASE + 32'h8, 32'hA3);
    repeat (19) tick();
    chk("TxBusy_mid_frame", {31'h0, TxBusy}, 32'h1);
    chk("TxD_bit3", {31'h0, TxD}, 32'h0);
    reset = 1'b0;
    #1;
    chk("abort_TxD", {31'h0, TxD}, 32'h1);
    chk("abort_TxBusy", {31'h0, TxBusy}, 32'h0);
    chk("abort_PortOut", PortOut, 32'h0);
    load(BASE + 32'hC, 32'h0 | PB, 1'b1);
    load(BASE + 32'h4, 32'h0, 1'b1);
    reset = 1'b1;
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (TxBusy || !TxD) bad++;
    end
    chk("no_resume", bad, 0);
    tick();
    load(BASE + 32'hC, 32'h0 | PB, 1'b1);
    repeat (2) tick();
    chk("rd_q_drained", rd_exp_q.size(), 0);
    chk("tx_q_final", tx_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mmio_uart_port.md
# mmio_uart_port

Memory-mapped I/O responder on the single-cycle MIPS core's data bus (Address/WriteData/MemWrite/MemRead). It decodes a 16-byte window and serves loads and stores as the target, where the core is the initiator. The window holds an output port register, a synchronized input port, and a 4-entry FIFO feeding an 8N1 serial transmitter. It sits beside the data RAM; the top level selects its ReadData when Hit is high.

## Interface
- BASE_ADDR, 32'h1001_0000, window base; bits [3:0] must be zero.
- CLK_DIV, 16, clocks per serial bit; legal range 2..65535.
- FIFO_DEPTH, 4, TX FIFO entries; must be a power of two, 2..16.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- Address  in  32  byte address from the ALU result.
- WriteData  in  32  store data (rt).
- MemWrite  in  1  store strobe, sampled on the clk rising edge.
- MemRead  in  1  load strobe.
- ReadData  out  32  combinational load data.
- Hit  out  1  combinational; high when Address[31:4]==BASE_ADDR[31:4].
- PortIn  in  8  asynchronous external input.
- PortOut  out  32  output port register.
- TxD  out  1  serial line; idles high.
- TxBusy  out  1  high while a frame is on the line.

## Operation
- Register map (offset Address[3:2]; Address[1:0] ignored):
  - 0x0 PORT_OUT: read/write, 32 bits.
  - 0x4 PORT_IN: read-only; zero-extended value of the 2-flop synchronized PortIn.
  - 0x8 TX_DATA: write-only; the write pushes WriteData[7:0]. Reads return 0.
  - 0xC STATUS: bit0 full, bit1 TxBusy, bit2 overflow (sticky), bits[8:4] FIFO count, other bits 0. Writing 1 to bit2 clears overflow; other bits are ignored.
- ReadData = selected register when MemRead && Hit, else 32'h0.
- Writes are ignored when Hit is low.
- FIFO push when full: data is dropped and overflow is set. Full is evaluated before the edge, so a push in the same cycle as a pop is still rejected.
- Push and pop in the same cycle when not full: count is unchanged and both actions take effect.
- TX state machine IDLE -> START -> DATA -> STOP -> IDLE (PARITY is inserted before STOP when enabled).
  - IDLE: TxD=1. If the FIFO is not empty, pop into the shift register and go to START.
  - START: TxD=0 for CLK_DIV cycles.
  - DATA: 8 bits, LSB first, CLK_DIV cycles each, tracked by a 3-bit bit counter.
  - STOP: TxD=1 for CLK_DIV cycles, then IDLE.
- TxBusy = (state != IDLE).

## Timing
- Reset values (asynchronous, immediate):
  - PortOut=0, TxD=1, TxBusy=0, FIFO empty, overflow=0.
  - Synchronizer flops = 0, state=IDLE.
  - Any frame in progress is aborted.
- PORT_IN latency: a PortIn change is visible in a load 2 rising edges later.
- A PORT_OUT store at edge N updates PortOut immediately after edge N.
- A TX_DATA store at edge N with an idle transmitter:
  - count=1 after edge N.
  - Pop at edge N+1; TxD falls after edge N+1.
  - The frame lasts 10*CLK_DIV cycles (11*CLK_DIV with parity).
- Back-to-back frames: IDLE lasts exactly 1 cycle between a STOP and the next START.
- The baud counter reloads on every state change; there is no fractional-bit drift.
- Overflow and a clear requested in the same cycle: set wins.

## Configuration
- MMIO_UART_PARITY_EN defined: a PARITY state is inserted after DATA. It drives the even-parity bit (XOR of the 8 data bits) for CLK_DIV cycles. STATUS bit3 reads 1.
- MMIO_UART_PARITY_EN undefined: no PARITY state, 10-bit frame, STATUS bit3 reads 0.

## Test plan
All scenarios use CLK_DIV=4.
- Reset low mid-frame (DATA bit 3) -> TxD=1, TxBusy=0, PortOut=0, STATUS=0 immediately; no frame resumes after release.
- Store 0xDEADBEEF to BASE+0x0, then load BASE+0x0 -> ReadData=0xDEADBEEF. Load BASE+0x10 -> Hit=0, ReadData=0.
- PortIn=0xA5 held -> load BASE+0x4 returns 0x000000A5 from the 2nd edge on and 0 before.
- Store 0x55 to BASE+0x8 -> TxD falls 1 cycle later, followed by 0,1,0,1,0,1,0,1,0 then stop 1, each 4 cycles. TxBusy is high for 40 cycles (44 with parity, parity bit=0).
- Six stores 0x01..0x06 in consecutive cycles -> first is popped, count peaks at 4, 6th is dropped, STATUS bit2=1. Frames 0x01..0x05 are sent in order with a 1-cycle IDLE gap between them.
- Write 0x4 to BASE+0xC -> overflow clears. Repeat with an overflowing push in the same cycle -> overflow stays 1.
